// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and the NOP bubble.
// Also holds the immediate-extension and ALU-select helpers used by the decode stage.
package riscv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    function automatic logic [31:0] extend_imm(input logic [31:0] i, input imm_src_e src);
        case (src)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // sub only selects subtraction for funct3=000; callers pass 0 for I-type ALU ops.
    function automatic alu_ctrl_e alu_from_funct(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b010:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic alu_funct_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
    endfunction

endpackage

// File: rtl/register_file.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous write port.
// x0 is hardwired to zero; a same-cycle write is forwarded to matching read ports.
module register_file #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [32];
    logic            wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Write-through forwarding closes the writeback-to-decode hazard without a negedge write.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
        if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register with stall/flush, control decode, immediate
// extension and the integrated register file feeding the ID/EX register.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [31:0]     InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ImmExtD,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [4:0]      RdD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            RegWriteD,
    output logic [1:0]      ResultSrcD,
    output logic            MemWriteD,
    output logic            JumpD,
    output logic            BranchD,
    output logic            ALUSrcD,
    output logic [2:0]      ALUControlD,
    output logic            IllegalD
);

    logic [31:0] instr_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        imm_en;
    imm_src_e    imm_src;

    // Flush wins over stall so a taken branch always squashes the held instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d  <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            instr_d  <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (!StallD) begin
            instr_d  <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end
    end

    assign opcode   = instr_d[6:0];
    assign funct3   = instr_d[14:12];
    assign funct7_5 = instr_d[30];
    assign Rs1D     = instr_d[19:15];
    assign Rs2D     = instr_d[24:20];
    assign RdD      = instr_d[11:7];

    always_comb begin
        RegWriteD   = 1'b0;
        ResultSrcD  = RES_ALU;
        MemWriteD   = 1'b0;
        JumpD       = 1'b0;
        BranchD     = 1'b0;
        ALUSrcD     = 1'b0;
        ALUControlD = ALU_ADD;
        IllegalD    = 1'b0;
        imm_en      = 1'b0;
        imm_src     = IMM_I;
        case (opcode)
            OP_LOAD: if (funct3 == 3'b010) begin
                RegWriteD  = 1'b1;
                ResultSrcD = RES_MEM;
                ALUSrcD    = 1'b1;
                imm_en     = 1'b1;
            end
            OP_STORE: if (funct3 == 3'b010) begin
                MemWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                imm_en    = 1'b1;
                imm_src   = IMM_S;
            end
            OP_RTYPE: if (alu_funct_ok(funct3)) begin
                RegWriteD   = 1'b1;
                ALUControlD = alu_from_funct(funct3, funct7_5);
            end
            OP_IALU: if (alu_funct_ok(funct3)) begin
                RegWriteD   = 1'b1;
                ALUSrcD     = 1'b1;
                ALUControlD = alu_from_funct(funct3, 1'b0);
                imm_en      = 1'b1;
            end
            OP_BRANCH: if (funct3 == 3'b000) begin
                BranchD     = 1'b1;
                ALUControlD = ALU_SUB;
                imm_en      = 1'b1;
                imm_src     = IMM_B;
            end
            OP_JAL: begin
                JumpD      = 1'b1;
                RegWriteD  = 1'b1;
                ResultSrcD = RES_PC4;
                imm_en     = 1'b1;
                imm_src    = IMM_J;
            end
            default: IllegalD = 1'b1;
        endcase
    end

    assign ImmExtD = imm_en ? extend_imm(instr_d, imm_src) : '0;

    register_file #(
        .XLEN(XLEN)
    ) u_register_file (
        .clk  (clk),
        .reset(reset),
        .ra1  (Rs1D),
        .ra2  (Rs2D),
        .we   (RegWriteW),
        .wa   (RdW),
        .wd   (ResultW),
        .rd1  (RD1D),
        .rd2  (RD2D)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver updates an arithmetic reference model and
// queues expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallD = 1'b0, FlushD = 1'b0;
    logic [31:0] InstrF = 32'h0, PCF = 32'h0, PCPlus4F = 32'h0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = 5'd0;
    logic [31:0] ResultW = 32'h0;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;

    decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .IllegalD(IllegalD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc, pc4, instr;
        logic [4:0]  rs1, rs2, rd;
        logic        regw;
        logic [1:0]  rsrc;
        logic        memw, jump, branch, alusrc;
        logic [2:0]  aluc;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_instr, m_pc, m_pc4;
    logic [31:0] m_regs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic int alu_code(input logic [2:0] f3, input logic sub);
        if (f3 == 3'd0) return sub ? 1 : 0;
        if (f3 == 3'd7) return 2;
        if (f3 == 3'd6) return 3;
        return 5;
    endfunction

    // Reference decode, computed from the instruction-set rules with integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t       e;
        logic [2:0] f3;
        int         v;
        bit         alu_ok;
        e      = '0;
        f3     = i[14:12];
        alu_ok = (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd2);
        case (i[6:0])
            7'h03: if (f3 == 3'd2) begin
                e.regw = 1; e.rsrc = 2'd1; e.alusrc = 1;
                e.imm = $signed(i) >>> 20;
            end
            7'h23: if (f3 == 3'd2) begin
                e.memw = 1; e.alusrc = 1;
                v = ($signed(i) >>> 25) * 32 + int'(i[11:7]);
                e.imm = v;
            end
            7'h33: if (alu_ok) begin
                e.regw = 1; e.aluc = 3'(alu_code(f3, i[30]));
            end
            7'h13: if (alu_ok) begin
                e.regw = 1; e.alusrc = 1; e.aluc = 3'(alu_code(f3, 1'b0));
                e.imm = $signed(i) >>> 20;
            end
            7'h63: if (f3 == 3'd0) begin
                e.branch = 1; e.aluc = 3'd1;
                v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                e.imm = v;
            end
            7'h6F: begin
                e.jump = 1; e.regw = 1; e.rsrc = 2'd2;
                v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                    + int'(i[30:21]) * 2;
                e.imm = v;
            end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e       = ref_decode(m_instr);
        e.instr = m_instr;
        e.pc    = m_pc;
        e.pc4   = m_pc4;
        e.rs1   = m_instr[19:15];
        e.rs2   = m_instr[24:20];
        e.rd    = m_instr[11:7];
        e.rd1   = (RegWriteW && RdW != 0 && RdW == e.rs1) ? ResultW : m_regs[e.rs1];
        e.rd2   = (RegWriteW && RdW != 0 && RdW == e.rs2) ? ResultW : m_regs[e.rs2];
        return e;
    endfunction

    task automatic model_clear();
        m_instr = 32'h13; m_pc = 0; m_pc4 = 0;
        for (int k = 0; k < 32; k++) m_regs[k] = 0;
    endtask

    // One cycle: apply the edge that just occurred to the model, drive new inputs mid-cycle.
    task automatic step(input logic rst, input logic st, input logic fl, input logic [31:0] ins,
                        input logic [31:0] pc, input logic we, input logic [4:0] rd,
                        input logic [31:0] res);
        @(posedge clk);
        #1;
        if (reset) model_clear();
        else begin
            if (FlushD) begin m_instr = 32'h13; m_pc = 0; m_pc4 = 0; end
            else if (!StallD) begin m_instr = InstrF; m_pc = PCF; m_pc4 = PCPlus4F; end
            if (RegWriteW && RdW != 0) m_regs[RdW] = ResultW;
        end
        reset = rst; StallD = st; FlushD = fl; InstrF = ins; PCF = pc; PCPlus4F = pc + 4;
        RegWriteW = we; RdW = rd; ResultW = res;
        if (rst) model_clear();
        sb.push_back(expected());
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] pc);
        step(1'b0, 1'b0, 1'b0, ins, pc, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 8))
            0: r = {r[31:15], 3'b010, r[11:7], 7'h03};
            1: r = {r[31:15], 3'b010, r[11:7], 7'h23};
            2: r = {1'b0, r[30], 5'b0, r[24:7], 7'h33};
            3: r = {r[31:7], 7'h13};
            4: r = {r[31:15], 3'b000, r[11:7], 7'h63};
            5: r = {r[31:7], 7'h6F};
            6: r = {r[31:7], 7'h33};
            7: r = 32'h13;
            default: ;
        endcase
        return r;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("RD1D", RD1D, e.rd1);
                chk("RD2D", RD2D, e.rd2);
                chk("ImmExtD", ImmExtD, e.imm);
                chk("PCD", PCD, e.pc);
                chk("PCPlus4D", PCPlus4D, e.pc4);
                chk("Rs1D/Rs2D/RdD", {17'h0, Rs1D, Rs2D, RdD}, {17'h0, e.rs1, e.rs2, e.rd});
                chk("ctrl", {21'h0, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
                             ALUControlD, IllegalD},
                    {21'h0, e.regw, e.rsrc, e.memw, e.jump, e.branch, e.alusrc, e.aluc, e.illegal});
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_clear();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        // Fill a few registers, then reset asynchronously mid-cycle.
        step(1'b0, 1'b0, 1'b0, 32'h0010_0113, 32'h4, 1'b1, 5'd2, 32'h1234_5678);
        run(32'h0020_81B3, 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        run(32'h0050_0093, 32'h10);
        run(32'h0020_81B3, 32'h14);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h18, 1'b1, 5'd1, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h18, 1'b1, 5'd2, 32'h0000_0077);
        run(32'h0000_01B3, 32'h1C);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1, 5'd0, 32'hCAFE_F00D);
        run(32'h0000_0013, 32'h24);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0033, 32'h40, 1'b0, 5'd0, 32'h0);
        run(32'hFE00_0EE3, 32'h44);
        run(32'h0080_00EF, 32'h48);
        run(32'h0000_007F, 32'h4C);
        run(32'h0000_0013, 32'h50);
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), rand_instr(), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom), $urandom);
        end
        step(1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
